// File: rtl/modport_top.sv
// modport_top: PCIe 1-DW MRd/MWr completer bridging to an AXI4 master, one request in flight
// Ports: clk/rst; rx_req_tlp_* request sink; tx_cpl_tlp_* completion source;
//   completer_id for completion headers; max_payload_size ignored;
//   status_error_cor/uncor one-cycle pulses; m_axi_* AXI4 master.
// Macro MODPORT_TOP_ADDR64_EN enables 4DW (64-bit address) requests; without it they are unsupported.
`timescale 1ns/1ps
module modport_top #(
  parameter int TLP_DATA_WIDTH = 64,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH/32,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter int TLP_SEG_COUNT  = 1,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
  parameter int AXI_ID_WIDTH   = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [TLP_DATA_WIDTH-1:0]              rx_req_tlp_data,
  input  logic [TLP_SEG_COUNT*TLP_HDR_WIDTH-1:0] rx_req_tlp_hdr,
  input  logic [TLP_SEG_COUNT-1:0]               rx_req_tlp_valid,
  input  logic [TLP_SEG_COUNT-1:0]               rx_req_tlp_sop,
  input  logic [TLP_SEG_COUNT-1:0]               rx_req_tlp_eop,
  output logic                                   rx_req_tlp_ready,
  output logic [TLP_DATA_WIDTH-1:0]              tx_cpl_tlp_data,
  output logic [TLP_STRB_WIDTH-1:0]              tx_cpl_tlp_strb,
  output logic [TLP_SEG_COUNT*TLP_HDR_WIDTH-1:0] tx_cpl_tlp_hdr,
  output logic [TLP_SEG_COUNT-1:0]               tx_cpl_tlp_valid,
  output logic [TLP_SEG_COUNT-1:0]               tx_cpl_tlp_sop,
  output logic [TLP_SEG_COUNT-1:0]               tx_cpl_tlp_eop,
  input  logic                                   tx_cpl_tlp_ready,
  input  logic [15:0]                            completer_id,
  input  logic [2:0]                             max_payload_size,
  output logic                                   status_error_cor,
  output logic                                   status_error_uncor,
  output logic [AXI_ID_WIDTH-1:0]                m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]              m_axi_awaddr,
  output logic [7:0]                             m_axi_awlen,
  output logic [2:0]                             m_axi_awsize,
  output logic [1:0]                             m_axi_awburst,
  output logic                                   m_axi_awlock,
  output logic [3:0]                             m_axi_awcache,
  output logic [2:0]                             m_axi_awprot,
  output logic                                   m_axi_awvalid,
  input  logic                                   m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]              m_axi_wdata,
  output logic [AXI_STRB_WIDTH-1:0]              m_axi_wstrb,
  output logic                                   m_axi_wlast,
  output logic                                   m_axi_wvalid,
  input  logic                                   m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]                m_axi_bid,
  input  logic [1:0]                             m_axi_bresp,
  input  logic                                   m_axi_bvalid,
  output logic                                   m_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]                m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]              m_axi_araddr,
  output logic [7:0]                             m_axi_arlen,
  output logic [2:0]                             m_axi_arsize,
  output logic [1:0]                             m_axi_arburst,
  output logic                                   m_axi_arlock,
  output logic [3:0]                             m_axi_arcache,
  output logic [2:0]                             m_axi_arprot,
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]                m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]              m_axi_rdata,
  input  logic [1:0]                             m_axi_rresp,
  input  logic                                   m_axi_rlast,
  input  logic                                   m_axi_rvalid,
  output logic                                   m_axi_rready
);
`ifdef MODPORT_TOP_ADDR64_EN
  localparam logic A64 = 1'b1;
`else
  localparam logic A64 = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, CPL} state_t;
  state_t                    r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_STRB_WIDTH-1:0] r_wstrb;
  logic [31:0]               r_wdata, r_rdata;
  logic [15:0]               r_rid;
  logic [7:0]                r_tag;
  logic [2:0]                r_status;
  logic                      r_ur, r_awvalid, r_wvalid, r_arvalid, r_cpl_valid, r_cor, r_uncor;
  logic [127:0] w_hdr;
  logic [63:0]  w_a64;
  logic         w_ok, w_take, w_full, w_unused;
  assign w_hdr  = rx_req_tlp_hdr[127:0];
  // 4DW headers carry the low address in DW3; 3DW headers in DW2
  assign w_a64  = w_hdr[125] ? w_hdr[63:0] : {32'h0, w_hdr[63:32]};
  assign w_ok   = w_hdr[124:120] == 5'd0 && w_hdr[105:96] == 10'd1 && !w_hdr[127] && (A64 || !w_hdr[125]);
  assign w_take = rx_req_tlp_valid[0] && rx_req_tlp_ready;
  assign w_full = rx_req_tlp_sop[0] && rx_req_tlp_eop[0];
  assign w_unused = ^{max_payload_size, m_axi_bid, m_axi_rid, m_axi_rlast,
                      rx_req_tlp_data[TLP_DATA_WIDTH-1:32], w_hdr[119:106], w_hdr[71:68]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_cpl_valid <= 1'b0;
      r_cor       <= 1'b0;
      r_uncor     <= 1'b0;
    end else begin
      r_cor   <= 1'b0;
      r_uncor <= 1'b0;
      case (r_state)
        IDLE: if (w_take) begin
          r_addr   <= AXI_ADDR_WIDTH'(w_a64) & ~AXI_ADDR_WIDTH'(3);
          r_wdata  <= rx_req_tlp_data[31:0];
          r_wstrb  <= AXI_STRB_WIDTH'(w_hdr[67:64]) << {w_a64[2], 2'b00};
          r_rid    <= w_hdr[95:80];
          r_tag    <= w_hdr[79:72];
          r_rdata  <= 32'h0;
          r_ur     <= 1'b1;
          r_status <= 3'b001;
          if (!w_full) r_uncor <= 1'b1;
          else if (w_ok && w_hdr[126]) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= WR_ADDR;
          end else if (w_ok) begin
            r_arvalid <= 1'b1;
            r_state   <= RD_ADDR;
          end else begin
            r_uncor <= 1'b1;
            if (!w_hdr[126]) begin
              r_cpl_valid <= 1'b1;
              r_state     <= CPL;
            end
          end
        end
        WR_ADDR: begin
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready) r_wvalid <= 1'b0;
          if ((!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready)) r_state <= WR_RESP;
        end
        WR_RESP: if (m_axi_bvalid) begin
          r_cor   <= |m_axi_bresp;
          r_state <= IDLE;
        end
        RD_ADDR: if (m_axi_arready) begin
          r_arvalid <= 1'b0;
          r_state   <= RD_DATA;
        end
        RD_DATA: if (m_axi_rvalid) begin
          r_rdata     <= m_axi_rdata[{r_addr[2], 5'b0} +: 32];
          r_ur        <= 1'b0;
          r_status    <= |m_axi_rresp ? 3'b100 : 3'b000;
          r_cor       <= |m_axi_rresp;
          r_cpl_valid <= 1'b1;
          r_state     <= CPL;
        end
        CPL: if (tx_cpl_tlp_ready) begin
          r_cpl_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign rx_req_tlp_ready   = r_state == IDLE;
  assign status_error_cor   = r_cor;
  assign status_error_uncor = r_uncor;
  assign tx_cpl_tlp_valid   = TLP_SEG_COUNT'(r_cpl_valid);
  assign tx_cpl_tlp_sop     = TLP_SEG_COUNT'(r_cpl_valid);
  assign tx_cpl_tlp_eop     = TLP_SEG_COUNT'(r_cpl_valid);
  assign tx_cpl_tlp_strb    = TLP_STRB_WIDTH'(1);
  assign tx_cpl_tlp_data    = TLP_DATA_WIDTH'(r_rdata);
  // UR is a dataless Cpl (fmt 000, length 0); otherwise CplD with one DW
  assign tx_cpl_tlp_hdr = (TLP_SEG_COUNT*TLP_HDR_WIDTH)'({r_ur ? 32'h0A00_0000 : 32'h4A00_0001,
                            completer_id, r_status, 1'b0, 12'd4,
                            r_rid, r_tag, 1'b0, r_addr[6:2], 2'b00, 32'h0});
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b010;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = {(AXI_DATA_WIDTH/32){r_wdata}};
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_state == WR_RESP;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'd2;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_state == RD_DATA;
endmodule

// File: tb/tb_modport_top.sv
// tb_modport_top: randomized self-checking bench for modport_top against a transaction-level model
`timescale 1ns/1ps
module tb_modport_top;
`ifdef MODPORT_TOP_ADDR64_EN
  localparam bit A64 = 1'b1;
`else
  localparam bit A64 = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [63:0] rx_req_tlp_data = 0;
  logic [127:0] rx_req_tlp_hdr = 0;
  logic rx_req_tlp_valid = 0, rx_req_tlp_sop = 0, rx_req_tlp_eop = 0, rx_req_tlp_ready;
  logic [63:0] tx_cpl_tlp_data;
  logic [1:0] tx_cpl_tlp_strb;
  logic [127:0] tx_cpl_tlp_hdr;
  logic tx_cpl_tlp_valid, tx_cpl_tlp_sop, tx_cpl_tlp_eop, tx_cpl_tlp_ready = 0;
  logic [15:0] completer_id = 16'hABCD;
  logic [2:0] max_payload_size = 3'd0;
  logic status_error_cor, status_error_uncor;
  logic [7:0] m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0] m_axi_awburst, m_axi_arburst;
  logic m_axi_awlock, m_axi_arlock, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [3:0] m_axi_awcache, m_axi_arcache;
  logic [63:0] m_axi_wdata;
  logic [7:0] m_axi_wstrb;
  logic m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0, m_axi_arready = 0, m_axi_rvalid = 0, m_axi_rlast = 0;
  logic [7:0] m_axi_bid = 0, m_axi_rid = 0;
  logic [1:0] m_axi_bresp = 0, m_axi_rresp = 0;
  logic [63:0] m_axi_rdata = 0;
  int checks = 0, errors = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, n_cpl = 0, n_cor = 0, n_uncor = 0;
  int e_aw = 0, e_w = 0, e_ar = 0, e_cpl = 0, e_cor = 0, e_uncor = 0;
  modport_top dut (
    .clk(clk), .rst(rst),
    .rx_req_tlp_data(rx_req_tlp_data), .rx_req_tlp_hdr(rx_req_tlp_hdr), .rx_req_tlp_valid(rx_req_tlp_valid),
    .rx_req_tlp_sop(rx_req_tlp_sop), .rx_req_tlp_eop(rx_req_tlp_eop), .rx_req_tlp_ready(rx_req_tlp_ready),
    .tx_cpl_tlp_data(tx_cpl_tlp_data), .tx_cpl_tlp_strb(tx_cpl_tlp_strb), .tx_cpl_tlp_hdr(tx_cpl_tlp_hdr),
    .tx_cpl_tlp_valid(tx_cpl_tlp_valid), .tx_cpl_tlp_sop(tx_cpl_tlp_sop), .tx_cpl_tlp_eop(tx_cpl_tlp_eop),
    .tx_cpl_tlp_ready(tx_cpl_tlp_ready), .completer_id(completer_id), .max_payload_size(max_payload_size),
    .status_error_cor(status_error_cor), .status_error_uncor(status_error_uncor),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst) begin
    if (m_axi_awvalid && m_axi_awready) n_aw <= n_aw + 1;
    if (m_axi_wvalid && m_axi_wready) n_w <= n_w + 1;
    if (m_axi_arvalid && m_axi_arready) n_ar <= n_ar + 1;
    if (tx_cpl_tlp_valid && tx_cpl_tlp_ready) n_cpl <= n_cpl + 1;
    if (status_error_cor) n_cor <= n_cor + 1;
    if (status_error_uncor) n_uncor <= n_uncor + 1;
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] exp_hdr(input bit ur, input logic [2:0] st, input logic [15:0] rid,
                                           input logic [7:0] tag, input logic [31:0] a);
    return {ur ? 32'h0A00_0000 : 32'h4A00_0001, completer_id, st, 1'b0, 12'd4, rid, tag, 1'b0, a[6:0], 32'h0};
  endfunction
  task automatic send(input logic [127:0] h, input logic [31:0] d, input bit s, input bit e);
    @(negedge clk);
    chk("rx_ready", rx_req_tlp_ready, 1);
    rx_req_tlp_hdr = h;
    rx_req_tlp_data = {$urandom, d};
    rx_req_tlp_valid = 1; rx_req_tlp_sop = s; rx_req_tlp_eop = e;
    @(negedge clk);
    rx_req_tlp_valid = 0; rx_req_tlp_sop = 0; rx_req_tlp_eop = 0;
  endtask
  task automatic cpl_chk(input logic [127:0] eh, input logic [31:0] ed, input bit ur, input int hold);
    logic [127:0] h0;
    logic [63:0] d0;
    chk("cpl_flags", {tx_cpl_tlp_valid, tx_cpl_tlp_sop, tx_cpl_tlp_eop, tx_cpl_tlp_strb}, 5'b11101);
    chk("cpl_hdr", tx_cpl_tlp_hdr, eh);
    if (!ur) chk("cpl_data", tx_cpl_tlp_data[31:0], ed);
    h0 = tx_cpl_tlp_hdr; d0 = tx_cpl_tlp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("cpl_hold", {tx_cpl_tlp_hdr, tx_cpl_tlp_data, tx_cpl_tlp_valid, rx_req_tlp_ready}, {h0, d0, 1'b1, 1'b0});
    end
    tx_cpl_tlp_ready = 1;
    @(negedge clk);
    tx_cpl_tlp_ready = 0;
    chk("cpl_done", {tx_cpl_tlp_valid, rx_req_tlp_ready}, 2'b01);
  endtask
  task automatic run(input logic [2:0] fmt, input logic [4:0] typ, input logic [9:0] len, input logic [7:0] tag,
                     input logic [3:0] be, input logic [31:0] dw2, input logic [31:0] dw3, input logic [31:0] dat,
                     input logic [63:0] rd, input logic [1:0] rsp, input int hold, input bit s, input bit e,
                     input bit rst_mid);
    logic [15:0] rid;
    logic [31:0] addr;
    logic [7:0] es;
    bit ok, a, w;
    int t, dly;
    rid = 16'($urandom);
    addr = (fmt[0] ? dw3 : dw2) & ~32'd3;
    ok = typ == 0 && len == 1 && !fmt[2] && (A64 || !fmt[0]);
    send({fmt, typ, 14'h0, len, rid, tag, 4'h0, be, dw2, dw3}, dat, s, e);
    if (!(s && e) || (!ok && fmt[1])) begin
      e_uncor++;
      chk("drop_quiet", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, tx_cpl_tlp_valid}, 0);
    end else if (!ok) begin
      e_uncor++; e_cpl++;
      chk("ur_no_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
      cpl_chk(exp_hdr(1, 3'b001, rid, tag, addr), 0, 1, hold);
    end else if (fmt[1]) begin
      e_aw++; e_w++;
      es = 8'(be) << (addr[2] ? 4 : 0);
      chk("aw", {m_axi_awvalid, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                 m_axi_awlock, m_axi_awcache, m_axi_awprot},
                {1'b1, 8'h0, addr, 8'h0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010});
      chk("w", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast}, {1'b1, dat, dat, es, 1'b1});
      a = 0; w = 0;
      for (t = 0; t < 40 && !(a && w); t++) begin
        m_axi_awready = 1'($urandom_range(0, 1));
        m_axi_wready = 1'($urandom_range(0, 1));
        #1;
        if (m_axi_awvalid && m_axi_awready) a = 1;
        if (m_axi_wvalid && m_axi_wready) w = 1;
        @(negedge clk);
      end
      m_axi_awready = 0; m_axi_wready = 0;
      if (!(a && w)) chk("aw_w_timeout", 0, 1);
      if (rst_mid) begin
        rst = 1;
        @(negedge clk);
        chk("rst_out", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                        tx_cpl_tlp_valid, status_error_cor, status_error_uncor}, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_idle", rx_req_tlp_ready, 1);
      end else begin
        dly = $urandom_range(0, 2);
        repeat (dly) begin
          chk("bready_wait", m_axi_bready, 1);
          @(negedge clk);
        end
        m_axi_bvalid = 1; m_axi_bresp = rsp;
        #1 chk("bready", m_axi_bready, 1);
        @(negedge clk);
        m_axi_bvalid = 0;
        if (rsp != 0) e_cor++;
      end
    end else begin
      e_ar++; e_cpl++;
      chk("ar", {m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                 m_axi_arlock, m_axi_arcache, m_axi_arprot},
                {1'b1, 8'h0, addr, 8'h0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010});
      a = 0;
      for (t = 0; t < 40 && !a; t++) begin
        m_axi_arready = 1'($urandom_range(0, 1));
        #1;
        if (m_axi_arvalid && m_axi_arready) a = 1;
        @(negedge clk);
      end
      m_axi_arready = 0;
      if (!a) chk("ar_timeout", 0, 1);
      dly = $urandom_range(0, 2);
      repeat (dly) @(negedge clk);
      m_axi_rvalid = 1; m_axi_rdata = rd; m_axi_rresp = rsp; m_axi_rlast = 1;
      #1 chk("rready", m_axi_rready, 1);
      @(negedge clk);
      m_axi_rvalid = 0;
      if (rsp != 0) e_cor++;
      cpl_chk(exp_hdr(0, rsp != 0 ? 3'b100 : 3'b000, rid, tag, addr), addr[2] ? rd[63:32] : rd[31:0], 0, hold);
    end
    @(negedge clk);
    chk("counts", {16'(n_aw), 16'(n_w), 16'(n_ar), 16'(n_cpl), 16'(n_cor), 16'(n_uncor)},
                  {16'(e_aw), 16'(e_w), 16'(e_ar), 16'(e_cpl), 16'(e_cor), 16'(e_uncor)});
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [2:0] fmt;
    logic [4:0] typ;
    logic [9:0] len;
    logic [1:0] se;
    int k;
    repeat (3) @(negedge clk);
    chk("reset_out", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                      tx_cpl_tlp_valid, status_error_cor, status_error_uncor}, 0);
    rst = 0;
    @(negedge clk);
    chk("reset_ready", rx_req_tlp_ready, 1);
    run(3'b010, 0, 1, 8'h01, 4'hF, 32'h1004, 0, 32'hDEADBEEF, 0, 2'b00, 0, 1, 1, 0);
    run(3'b000, 0, 1, 8'h12, 4'hF, 32'h2000, 0, 0, {32'h1111_2222, 32'hCAFEF00D}, 2'b00, 0, 1, 1, 0);
    run(3'b000, 0, 1, 8'h34, 4'hF, 32'h2004, 0, 0, {32'h5555_6666, 32'h7777_8888}, 2'b10, 1, 1, 1, 0);
    run(3'b000, 0, 2, 8'h56, 4'hF, 32'h3000, 0, 0, 0, 2'b00, 0, 1, 1, 0);
    run(3'b010, 0, 2, 8'h57, 4'hF, 32'h3000, 0, 32'h1234, 0, 2'b00, 0, 1, 1, 0);
    run(3'b000, 0, 1, 8'h78, 4'h3, 32'h4048, 0, 0, {32'hA5A5_5A5A, 32'h0F0F_F0F0}, 2'b00, 5, 1, 1, 0);
    run(3'b010, 0, 1, 8'h9A, 4'h3, 32'h5000, 0, 32'hFEED, 0, 2'b00, 0, 1, 1, 1);
    run(3'b001, 0, 1, 8'hBC, 4'hF, 32'h0, 32'h0000_1234, 0, {32'h1, 32'h2}, 2'b00, 0, 1, 1, 0);
    run(3'b011, 0, 1, 8'hBD, 4'hF, 32'h0, 32'h0000_6664, 32'h99, 0, 2'b00, 0, 1, 1, 0);
    run(3'b000, 5'h04, 1, 8'hDE, 4'hF, 32'h6000, 0, 0, 0, 2'b00, 0, 1, 1, 0);
    run(3'b010, 0, 1, 8'hEF, 4'hF, 32'h7000, 0, 32'h5, 0, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      fmt = {1'b0, 1'($urandom_range(0, 1)), 1'b0};
      typ = 0; len = 1; se = 2'b11;
      if (k <= 2) fmt = 3'b010;
      else if (k <= 5) fmt = 3'b000;
      else if (k == 6) len = 10'($urandom_range(2, 1024));
      else if (k == 7) typ = 5'($urandom_range(1, 31));
      else if (k == 8) fmt[0] = 1'b1;
      else se = 2'($urandom_range(0, 2));
      run(fmt, typ, len, 8'($urandom), 4'($urandom), $urandom, $urandom, $urandom, {$urandom, $urandom},
          2'($urandom_range(0, 3)), $urandom_range(0, 3), se[1], se[0], $urandom_range(0, 15) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/modport_top.md
MODPORT_TOP -- requirements
Module: modport_top

Interface
REQ-001 SHALL have parameters: TLP_DATA_WIDTH 64, TLP payload width; TLP_STRB_WIDTH TLP_DATA_WIDTH/32, per-DW strobe; TLP_HDR_WIDTH 128, header width; TLP_SEG_COUNT 1, segments; AXI_DATA_WIDTH 64; AXI_ADDR_WIDTH 32; AXI_STRB_WIDTH AXI_DATA_WIDTH/8; AXI_ID_WIDTH 8.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk in 1 (all logic on rising edge); rst in 1.
REQ-003 SHALL have rx_req_tlp_data/hdr/valid/sop/eop as inputs (widths TLP_DATA_WIDTH, TLP_SEG_COUNT*TLP_HDR_WIDTH, TLP_SEG_COUNT each), and rx_req_tlp_ready as an output (1).
REQ-004 SHALL have tx_cpl_tlp_data/strb/hdr/valid/sop/eop as outputs (same widths, strb TLP_STRB_WIDTH), and tx_cpl_tlp_ready as an input (1).
REQ-005 SHALL have completer_id in 16 (used in completion header) and max_payload_size in 3 (reserved, ignored).
REQ-006 SHALL have status_error_cor out 1 and status_error_uncor out 1, each a single-cycle pulse.
REQ-007 SHALL be an AXI4 master: AW, W, B, AR and R channels with standard names m_axi_*, with widths per the parameters; len 8, size 3, burst 2, lock 1, cache 4, prot 3, resp 2.

Function
REQ-008 Request header DWs SHALL be: DW0=hdr[127:96] (fmt[127:125], type[124:120], length[105:96]); DW1=hdr[95:64] (requester_id[95:80], tag[79:72], first_be[67:64]); DW2=hdr[63:32]; DW3=hdr[31:0].
REQ-009 Supported requests SHALL be MRd (fmt 000/001, type 00000) and MWr (fmt 010/011, type 00000), both with length 1 DW; the 3DW address is DW2[31:2],2'b00.
REQ-010 The FSM SHALL have the states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, CPL, and exactly one request SHALL be outstanding; rx_req_tlp_ready=1 only in IDLE.
REQ-011 A TLP SHALL be accepted when valid&sop&eop&ready; the AXI request SHALL assert on the next cycle.
REQ-012 A write SHALL use awaddr=addr, awlen=0, awsize=2, awburst=01, awlock=0, awcache=0011, awprot=010, and awid=arid=0; the payload DW SHALL be replicated in both 32-bit lanes of wdata, with wstrb=first_be<<(addr[2]*4) and wlast=1.
REQ-013 AW and W SHALL be driven together; each valid SHALL drop independently on its handshake, and the FSM SHALL go to WR_RESP when both are done.
REQ-014 bready SHALL be 1 in WR_RESP; the FSM SHALL return to IDLE on bvalid, and bresp!=00 SHALL pulse status_error_cor; no completion is sent for a write.
REQ-015 A read SHALL use the same AR field values as REQ-012; rready SHALL be 1 in RD_DATA; the rdata lane SHALL be selected by addr[2] and registered.
REQ-016 A completion SHALL have tx_cpl_tlp_valid=sop=eop=1 and strb=1, with data[31:0]=the read DW.
REQ-017 The completion header SHALL be: DW0 fmt 010, type 01010, length 1; DW1 = {completer_id, status[15:13], 0, byte_count=4}; DW2 = {requester_id, tag, 0, lower_addr={addr[6:2],2'b00}}; DW3 = 0.
REQ-018 Completion status SHALL be 000 on rresp=00, else 100 (CA) plus a status_error_cor pulse.
REQ-019 The completion SHALL be held stable until tx_cpl_tlp_ready, then the FSM SHALL return to IDLE.
REQ-020 An unsupported non-posted request (bad type or length!=1 with fmt[1]=0) SHALL return a Cpl (fmt 000, length 0, status 001 UR) and pulse status_error_uncor.
REQ-021 An unsupported posted request SHALL be dropped with a status_error_uncor pulse.
REQ-022 A TLP with valid but not sop&eop SHALL be consumed and dropped with a status_error_uncor pulse.

Reset
REQ-023 While rst=1, all valid outputs, status pulses and bready/rready SHALL be 0, and the FSM SHALL be IDLE; rx_req_tlp_ready=1 on the first cycle after reset.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no completion.

Configuration
REQ-025 With ADDR64 support compiled in via the macro MODPORT_TOP_ADDR64_EN, 4DW headers (fmt[0]=1) SHALL use address {DW2,DW3}[AXI_ADDR_WIDTH-1:2],2'b00.
REQ-026 Without MODPORT_TOP_ADDR64_EN, 4DW requests SHALL be treated as unsupported per REQ-020/021.

Verification
REQ-027 MWr 3DW addr 0x1004, first_be F, data 0xDEADBEEF -> awaddr 0x1004, wdata[63:32]=0xDEADBEEF, wstrb 0xF0, no completion.
REQ-028 MRd 3DW addr 0x2000, tag 0x12, slave rdata[31:0]=0xCAFEF00D -> CplD status 000, tag 0x12, data[31:0]=0xCAFEF00D, lower_addr 0x00.
REQ-029 MRd with rresp=10 -> CplD status 100 and a status_error_cor pulse.
REQ-030 MRd with length 2 -> Cpl with status 001, no AR, and a status_error_uncor pulse; MWr with length 2 -> no AW and a status_error_uncor pulse.
REQ-031 Completion with tx_cpl_tlp_ready low for 5 cycles -> header and data stable, and rx_req_tlp_ready stays 0 until the completion handshake.
REQ-032 Assert rst during WR_RESP -> all valids 0 next cycle, IDLE, no completion.
